// File: rtl/reg_file_multi_port_pkg.sv
// Shared processor types for the integer and FP register files.
package ProcessorTypes;

   localparam int unsigned XLEN_DEFAULT      = 32;
   localparam int unsigned REG_COUNT_DEFAULT = 32;

   typedef logic [XLEN_DEFAULT-1:0]               word_t;
   typedef logic [$clog2(REG_COUNT_DEFAULT)-1:0]  reg_addr_t;

   typedef enum logic {
      INIT,
      READY
   } reg_file_state_t;

endpackage

// File: rtl/reg_file_multi_port_if.sv
// Register file bus: read, write and issue sides, plus the register file's own view.
interface reg_file_multi_port_if #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned REG_COUNT   = 32,
   parameter int unsigned READ_PORTS  = 2,
   parameter int unsigned WRITE_PORTS = 1
);
   localparam int unsigned AW = $clog2(REG_COUNT);

   logic [AW-1:0]          readAddr   [READ_PORTS];
   logic [XLEN-1:0]        readValue  [READ_PORTS];
   logic [READ_PORTS-1:0]  readBusy;

   logic [WRITE_PORTS-1:0] writeEnable;
   logic [AW-1:0]          writeAddr  [WRITE_PORTS];
   logic [XLEN-1:0]        writeValue [WRITE_PORTS];

   logic                   reserveEnable;
   logic [AW-1:0]          reserveAddr;

   modport readMaster  (output readAddr, input readValue, readBusy);
   modport writeMaster (output writeEnable, writeAddr, writeValue);
   modport issueMaster (output reserveEnable, reserveAddr);

   modport slave (
      input  readAddr, writeEnable, writeAddr, writeValue, reserveEnable, reserveAddr,
      output readValue, readBusy
   );
endinterface

// File: rtl/reg_file_multi_port_scoreboard.sv
// Per-register busy bits; a reservation outranks a same-cycle clearing write.
module reg_scoreboard #(
   parameter int unsigned REG_COUNT   = 32,
   parameter int unsigned WRITE_PORTS = 1
) (
   input  logic                         clk,
   input  logic                         rstN,
   input  logic                         enable,
   input  logic                         reserveEnable,
   input  logic [$clog2(REG_COUNT)-1:0] reserveAddr,
   input  logic [WRITE_PORTS-1:0]       writeEnable,
   input  logic [$clog2(REG_COUNT)-1:0] writeAddr [WRITE_PORTS],
   output logic [REG_COUNT-1:0]         busy,
   output logic [REG_COUNT-1:0]         clearMask
);
   logic [REG_COUNT-1:0] setMask;
   logic [REG_COUNT-1:0] clearRaw;

   always_comb begin
      setMask  = '0;
      clearRaw = '0;
      if (enable) begin
         if (reserveEnable && reserveAddr != '0) begin
            setMask[reserveAddr] = 1'b1;
         end
         for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
            if (writeEnable[p]) begin
               clearRaw[writeAddr[p]] = 1'b1;
            end
         end
      end
      clearMask = clearRaw & ~setMask;
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         busy <= '0;
      end else begin
         busy <= (busy | setMask) & ~clearMask;
      end
   end
endmodule

// File: rtl/reg_file_multi_port.sv
// N-read/M-write integer register file with optional bypass, busy scoreboard and post-reset zeroing.
module reg_file_multi_port
   import ProcessorTypes::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned REG_COUNT   = 32,
   parameter int unsigned READ_PORTS  = 2,
   parameter int unsigned WRITE_PORTS = 1,
   parameter int unsigned BYPASS      = 1
) (
   input  logic                  clk,
   input  logic                  rstN,
   reg_file_multi_port_if.slave  rf,
   output logic                  initDone
);
   localparam int unsigned AW = $clog2(REG_COUNT);

   reg_file_state_t      state, stateNext;
   logic [AW-1:0]        initCounter, counterNext;
   logic [XLEN-1:0]      regs [REG_COUNT];
   logic [REG_COUNT-1:0] busy;
   logic [REG_COUNT-1:0] clearMask;
   logic [AW-1:0]        wAddr [WRITE_PORTS];
   logic                 ready;

   assign ready    = (state == READY);
   assign initDone = ready;

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state       <= INIT;
         initCounter <= '0;
      end else begin
         state       <= stateNext;
         initCounter <= counterNext;
      end
   end

   always_comb begin
      stateNext   = state;
      counterNext = initCounter;
      case (state)
         INIT: begin
            if (initCounter == AW'(REG_COUNT - 1)) begin
               stateNext = READY;
            end else begin
               counterNext = initCounter + AW'(1);
            end
         end
         READY:   stateNext = READY;
         default: stateNext = INIT;
      endcase
   end

   // Storage has no reset; INIT zeroes one entry per cycle instead.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         regs[initCounter] <= '0;
      end else if (rstN) begin
         for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
            if (rf.writeEnable[p] && rf.writeAddr[p] != '0) begin
               regs[rf.writeAddr[p]] <= rf.writeValue[p];
            end
         end
      end
   end

   always_comb begin
      for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
         wAddr[p] = rf.writeAddr[p];
      end
   end

   reg_scoreboard #(
      .REG_COUNT   (REG_COUNT),
      .WRITE_PORTS (WRITE_PORTS)
   ) scoreboard (
      .clk           (clk),
      .rstN          (rstN),
      .enable        (ready && rstN),
      .reserveEnable (rf.reserveEnable),
      .reserveAddr   (rf.reserveAddr),
      .writeEnable   (rf.writeEnable),
      .writeAddr     (wAddr),
      .busy          (busy),
      .clearMask     (clearMask)
   );

   // Ascending port scan so the highest-index matching writer wins the bypass.
   always_comb begin
      rf.readBusy = '0;
      for (int unsigned i = 0; i < READ_PORTS; i++) begin
         rf.readValue[i] = '0;
         if (ready && rf.readAddr[i] != '0) begin
            rf.readValue[i] = regs[rf.readAddr[i]];
            if (BYPASS != 0) begin
               for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
                  if (rf.writeEnable[p] && rf.writeAddr[p] == rf.readAddr[i]) begin
                     rf.readValue[i] = rf.writeValue[p];
                  end
               end
            end
            rf.readBusy[i] = busy[rf.readAddr[i]] & ~((BYPASS != 0) && clearMask[rf.readAddr[i]]);
         end
      end
   end
endmodule

// File: tb/tb_reg_file_multi_port.sv
// Directed bench: dutA (2 write ports, bypass) and dutB (1 write port, no bypass) share clock and reset.
module tb_reg_file_multi_port;
   import ProcessorTypes::*;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   logic initDoneA, initDoneB;
   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   reg_file_multi_port_if #(.XLEN(32), .REG_COUNT(32), .READ_PORTS(2), .WRITE_PORTS(2)) ifA ();
   reg_file_multi_port_if #(.XLEN(32), .REG_COUNT(32), .READ_PORTS(2), .WRITE_PORTS(1)) ifB ();

   reg_file_multi_port #(
      .XLEN(32), .REG_COUNT(32), .READ_PORTS(2), .WRITE_PORTS(2), .BYPASS(1)
   ) dutA (
      .clk(clk), .rstN(rstN), .rf(ifA), .initDone(initDoneA)
   );

   reg_file_multi_port #(
      .XLEN(32), .REG_COUNT(32), .READ_PORTS(2), .WRITE_PORTS(1), .BYPASS(0)
   ) dutB (
      .clk(clk), .rstN(rstN), .rf(ifB), .initDone(initDoneB)
   );

   task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic driveIdle();
      ifA.writeEnable   = '0;
      ifA.reserveEnable = 1'b0;
      ifA.reserveAddr   = '0;
      for (int p = 0; p < 2; p++) begin
         ifA.writeAddr[p]  = '0;
         ifA.writeValue[p] = '0;
      end
      ifB.writeEnable   = '0;
      ifB.reserveEnable = 1'b0;
      ifB.reserveAddr   = '0;
      ifB.writeAddr[0]  = '0;
      ifB.writeValue[0] = '0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic runInit(input string tag);
      for (int c = 1; c <= 32; c++) begin
         nextCycle();
         if (c == 31) checkValue({tag, "_notDone31"}, 32'(initDoneA), 32'd0);
         if (c == 32) begin
            checkValue({tag, "_doneA32"}, 32'(initDoneA), 32'd1);
            checkValue({tag, "_doneB32"}, 32'(initDoneB), 32'd1);
         end
      end
   endtask

   task automatic checkAllZero(input string tag);
      for (int r = 0; r < 32; r++) begin
         ifA.readAddr[0] = 5'(r);
         #1;
         checkValue($sformatf("%s_r%0d", tag, r), ifA.readValue[0], 32'h0);
      end
   endtask

   initial begin
      driveIdle();
      for (int i = 0; i < 2; i++) begin
         ifA.readAddr[i] = '0;
         ifB.readAddr[i] = '0;
      end
      rstN = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkValue("resetInitDone", 32'(initDoneA), 32'd0);
      rstN = 1'b1;

      // INIT: edge 1 is counter 0; the write issued in cycle 10 must be ignored.
      for (int c = 1; c <= 32; c++) begin
         nextCycle();
         if (c == 10) begin
            ifA.writeEnable[0] = 1'b1; ifA.writeAddr[0] = 5'd5; ifA.writeValue[0] = 32'h1234;
            ifB.writeEnable[0] = 1'b1; ifB.writeAddr[0] = 5'd5; ifB.writeValue[0] = 32'h1234;
            ifA.readAddr[0] = 5'd5;
            #1;
            checkValue("initReadZero", ifA.readValue[0], 32'h0);
         end else if (c == 11) begin
            driveIdle();
         end
         if (c == 31) checkValue("init_notDone31", 32'(initDoneA), 32'd0);
         if (c == 32) begin
            checkValue("init_doneA32", 32'(initDoneA), 32'd1);
            checkValue("init_doneB32", 32'(initDoneB), 32'd1);
         end
      end
      checkAllZero("init");
      ifB.readAddr[0] = 5'd5;
      #1;
      checkValue("initLostWriteB", ifB.readValue[0], 32'h0);

      // Bypass vs. no bypass on register 7.
      ifA.writeEnable[0] = 1'b1; ifA.writeAddr[0] = 5'd7; ifA.writeValue[0] = 32'hDEADBEEF;
      ifB.writeEnable[0] = 1'b1; ifB.writeAddr[0] = 5'd7; ifB.writeValue[0] = 32'hDEADBEEF;
      ifA.readAddr[0] = 5'd7;
      ifB.readAddr[0] = 5'd7;
      @(negedge clk);
      checkValue("bypassSameCycleA", ifA.readValue[0], 32'hDEADBEEF);
      checkValue("noBypassOldB", ifB.readValue[0], 32'h0);
      nextCycle();
      driveIdle();
      #1;
      checkValue("writtenA", ifA.readValue[0], 32'hDEADBEEF);
      checkValue("noBypassNextB", ifB.readValue[0], 32'hDEADBEEF);

      // Two ports write register 3: port 1 wins.
      ifA.writeEnable = 2'b11;
      ifA.writeAddr[0] = 5'd3; ifA.writeValue[0] = 32'h11;
      ifA.writeAddr[1] = 5'd3; ifA.writeValue[1] = 32'h22;
      ifA.readAddr[0] = 5'd3;
      ifA.readAddr[1] = 5'd3;
      @(negedge clk);
      checkValue("conflictBypass0", ifA.readValue[0], 32'h22);
      checkValue("conflictBypass1", ifA.readValue[1], 32'h22);
      nextCycle();
      driveIdle();
      #1;
      checkValue("conflictStored", ifA.readValue[0], 32'h22);

      // Register 0 is hardwired.
      ifA.writeEnable[0] = 1'b1; ifA.writeAddr[0] = 5'd0; ifA.writeValue[0] = 32'hFFFFFFFF;
      ifA.reserveEnable = 1'b1; ifA.reserveAddr = 5'd0;
      ifA.readAddr[0] = 5'd0;
      nextCycle();
      driveIdle();
      #1;
      checkValue("reg0Value", ifA.readValue[0], 32'h0);
      checkValue("reg0Busy", 32'(ifA.readBusy[0]), 32'd0);

      // Scoreboard on register 9 (with bypass).
      ifA.readAddr[0] = 5'd9;
      ifA.reserveEnable = 1'b1; ifA.reserveAddr = 5'd9;
      nextCycle();
      driveIdle();
      #1;
      checkValue("busyCycle1", 32'(ifA.readBusy[0]), 32'd1);
      nextCycle();
      checkValue("busyCycle2", 32'(ifA.readBusy[0]), 32'd1);
      nextCycle();
      ifA.writeEnable[0] = 1'b1; ifA.writeAddr[0] = 5'd9; ifA.writeValue[0] = 32'h99;
      #1;
      checkValue("busyWriteCycle", 32'(ifA.readBusy[0]), 32'd0);
      nextCycle();
      driveIdle();
      #1;
      checkValue("busyAfterWrite", 32'(ifA.readBusy[0]), 32'd0);
      checkValue("reg9Value", ifA.readValue[0], 32'h99);

      // Same check without bypass: busy stays visible in the write cycle.
      ifB.readAddr[0] = 5'd9;
      ifB.reserveEnable = 1'b1; ifB.reserveAddr = 5'd9;
      nextCycle();
      driveIdle();
      nextCycle();
      ifB.writeEnable[0] = 1'b1; ifB.writeAddr[0] = 5'd9; ifB.writeValue[0] = 32'h5;
      #1;
      checkValue("noBypassBusyWrite", 32'(ifB.readBusy[0]), 32'd1);
      nextCycle();
      driveIdle();
      #1;
      checkValue("noBypassBusyAfter", 32'(ifB.readBusy[0]), 32'd0);

      // Reserve and write in the same cycle: reservation wins.
      ifA.reserveEnable = 1'b1; ifA.reserveAddr = 5'd9;
      ifA.writeEnable[0] = 1'b1; ifA.writeAddr[0] = 5'd9; ifA.writeValue[0] = 32'h77;
      nextCycle();
      driveIdle();
      #1;
      checkValue("reserveBeatsWrite", 32'(ifA.readBusy[0]), 32'd1);

      // Mid-operation reset with register 4 busy.
      ifA.reserveEnable = 1'b1; ifA.reserveAddr = 5'd4;
      ifA.readAddr[1] = 5'd4;
      nextCycle();
      driveIdle();
      #1;
      checkValue("reg4Busy", 32'(ifA.readBusy[1]), 32'd1);
      rstN = 1'b0;
      nextCycle();
      rstN = 1'b1;
      #1;
      checkValue("midResetInitDone", 32'(initDoneA), 32'd0);
      checkValue("midResetBusyForced", 32'(ifA.readBusy[1]), 32'd0);
      runInit("reinit");
      checkValue("reinitBusy4", 32'(ifA.readBusy[1]), 32'd0);
      ifA.readAddr[1] = 5'd9;
      #1;
      checkValue("reinitBusy9", 32'(ifA.readBusy[1]), 32'd0);
      checkAllZero("reinit");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/reg_file_multi_port.md
Name: reg_file_multi_port

Overview:
Parametrised integer register file succeeding the fixed 2-read/1-write register file. It provides N read ports and M write ports, optional same-cycle write-to-read bypass and a per-register busy scoreboard for issue stalling. The storage array has no reset, so a post-reset init sequencer zeroes it. It sits between the register-read and register-write stages of the core pipeline.

Parameters:
XLEN, 32, data width in bits.
REG_COUNT, 32, number of architectural registers; power of two, at least 2.
READ_PORTS, 2, number of read ports.
WRITE_PORTS, 1, number of write ports.
BYPASS, 1, 1 means same-cycle write data and write-clear are forwarded to read ports.

Ports:
clk  in  1  core clock.
rstN  in  1  reset; synchronous, active-low.
readAddr  in  READ_PORTS x log2(REG_COUNT)  read addresses.
readValue  out  READ_PORTS x XLEN  read data, combinational.
readBusy  out  READ_PORTS  scoreboard bit of readAddr[i].
writeEnable  in  WRITE_PORTS  write strobes.
writeAddr  in  WRITE_PORTS x log2(REG_COUNT)  write addresses.
writeValue  in  WRITE_PORTS x XLEN  write data.
reserveEnable  in  1  issue marks a destination register busy.
reserveAddr  in  log2(REG_COUNT)  register to reserve.
initDone  out  1  high once the array has been zeroed.

Behaviour:
- Reset and interface: one clock, clk. Reset rstN is synchronous and active-low.
- FSM states: INIT and READY.
  - rstN low: state goes to INIT, initCounter=0, all busy bits=0, initDone=0.
  - INIT: each cycle writes 0 to reg[initCounter], then increments initCounter. When initCounter==REG_COUNT-1, the next state is READY. INIT lasts exactly REG_COUNT cycles after rstN rises.
  - READY: initDone=1. The FSM stays in READY until the next reset.
  - Reset asserted in either state returns the FSM to INIT and restarts the counter at 0.
- During INIT:
  - All writeEnable and reserveEnable inputs are ignored.
  - readValue=0 and readBusy=0 on every port.
- Reads (READY):
  - readValue[i] = reg[readAddr[i]], combinational.
  - readAddr[i]==0 always returns 0. Register 0 is hardwired and never written, reserved or marked busy.
- Writes (READY):
  - Registered on the rising edge of clk.
  - If several write ports target the same address in the same cycle, the highest port index wins.
  - A write to register 0 is dropped.
- Bypass:
  - BYPASS=1: if any enabled write port targets readAddr[i] (nonzero) in the same cycle, readValue[i] takes that port's writeValue, using the same highest-index priority.
  - BYPASS=0: readValue[i] reflects the written value from the next cycle onward.
- Scoreboard:
  - reserveEnable with reserveAddr!=0 sets busy[reserveAddr] at the clock edge.
  - An enabled write clears busy[writeAddr] at the clock edge.
  - Reserve and write to the same address in the same cycle: reserve wins and the bit stays set, because the new producer supersedes the old one.
  - Reserving an already-busy register keeps it busy, with no error.
- readBusy:
  - readBusy[i] = busy[readAddr[i]].
  - With BYPASS=1, a same-cycle clearing write to that address forces readBusy[i]=0, unless the address is also reserved in that cycle.
- Width rules: addresses are unsigned. initCounter is log2(REG_COUNT) bits wide and stops advancing once INIT completes.
- Reset values: initDone=0, readBusy=0, readValue=0 (forced during INIT).

Decomposition:
- Shared package ProcessorTypes:
  - reg_addr_t, sized by REG_COUNT.
  - word_t, sized by XLEN.
  - Enum reg_file_state_t {INIT, READY}.
- A companion interface is updated alongside the block:
  - The register-read modport carries readAddr, readValue and readBusy arrays.
  - The register-write modport carries the write arrays.
  - The issue modport carries reserveEnable and reserveAddr.
- One sub-module: reg_scoreboard.
  - Holds the busy bits and the set/clear priority logic.
  - Kept separate so it can be reused by the FP register file.
- The data array, bypass muxes and init FSM stay in the top module.

Test Plan:
1. Init: release rstN and hold all inputs idle.
   - initDone rises exactly 32 cycles later.
   - Reading all 32 registers returns 0x00000000.
   - A write of 0x1234 to register 5 issued in cycle 10 of INIT is lost; register 5 still reads 0.
2. Bypass: with BYPASS=1, write 0xDEADBEEF to register 7 while readAddr[0]=7.
   - readValue[0]=0xDEADBEEF in the same cycle.
   - With BYPASS=0, readValue[0] shows the old value and updates to 0xDEADBEEF the next cycle.
3. Multi-write conflict: WRITE_PORTS=2, both ports write register 3 in one cycle, port0=0x11 and port1=0x22.
   - Register 3 reads 0x22.
   - The bypassed value in that cycle is also 0x22.
4. Register 0: write 0xFFFFFFFF to register 0 and reserve register 0.
   - readValue=0 and readBusy=0 on the following cycle.
5. Scoreboard: reserve register 9, then write register 9 two cycles later.
   - readBusy=1 for those two cycles.
   - readBusy=0 in the write cycle (bypass) and afterwards.
   - Reserve and write to register 9 in the same cycle leaves readBusy=1.
6. Mid-operation reset: with registers written and register 4 busy, pulse rstN low for one cycle.
   - Busy bits clear and initDone=0.
   - INIT restarts from counter 0 and all registers read 0 after 32 cycles.
